exibe_frame: RTL and testbench

EXIBE_FRAME -- requirements
Module: exibe_frame

---
 rtl/astrogenius_pkg.sv | 19 +
 rtl/exibe_frame_if.sv | 32 +++
 rtl/registrador_deslocamento_linha.sv | 30 +++
 rtl/exibe_frame.sv | 80 ++++++++
 tb/tb_exibe_frame.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/astrogenius_pkg.sv
// Shared AstroGenius definitions: frame geometry defaults and the
// exibe_frame state encoding.
package astrogenius_pkg;

    localparam int LINHAS_PADRAO  = 16;
    localparam int COLUNAS_PADRAO = 16;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_ESPERA        = 4'd1,
        ST_LE_LINHA      = 4'd2,
        ST_CARREGA       = 4'd3,
        ST_DESLOCA       = 4'd4,
        ST_TRAVA         = 4'd5,
        ST_PROXIMA_LINHA = 4'd6,
        ST_SINALIZA      = 4'd7
    } estado_t;

endpackage

// File: rtl/exibe_frame_if.sv
// Signal bundle between exibe_frame, the frame memory, the frame generator
// and the serial display driver.
interface exibe_frame_if import astrogenius_pkg::*; #(
    parameter int COLUNAS = COLUNAS_PADRAO
) ();

    logic               fim_gera_frame;
    logic [COLUNAS-1:0] dado_frame;
    logic               le_frame;
    logic [3:0]         endereco_frame;
    logic               dado_serial;
    logic               strobe_serial;
    logic               trava_linha;
    logic [3:0]         linha_ativa;
    logic               ocupado;
    logic               fim_exibe;
    logic [3:0]         db_estado;

    // master is the display controller; slave is its environment.
    modport master (
        input  fim_gera_frame, dado_frame,
        output le_frame, endereco_frame, dado_serial, strobe_serial,
               trava_linha, linha_ativa, ocupado, fim_exibe, db_estado
    );

    modport slave (
        output fim_gera_frame, dado_frame,
        input  le_frame, endereco_frame, dado_serial, strobe_serial,
               trava_linha, linha_ativa, ocupado, fim_exibe, db_estado
    );

endinterface

// File: rtl/registrador_deslocamento_linha.sv
// Row shift register: parallel load from frame memory, then shifts out
// MSB first with zero fill.
module registrador_deslocamento_linha import astrogenius_pkg::*; #(
    parameter int COLUNAS = COLUNAS_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic               desloca,
    input  logic [COLUNAS-1:0] dado,
    output logic               msb
);

    logic [COLUNAS-1:0] linha_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            linha_q <= '0;
        end else if (carrega) begin
            linha_q <= dado;
        end else if (desloca) begin
            linha_q <= linha_q << 1;
        end
    end

    assign msb = linha_q[COLUNAS-1];

endmodule

// File: rtl/exibe_frame.sv
// Frame display controller: reads each frame-memory row, shifts it out
// serially, latches it on the display and signals frame completion.
module exibe_frame import astrogenius_pkg::*; #(
    parameter int LINHAS  = LINHAS_PADRAO,
    parameter int COLUNAS = COLUNAS_PADRAO
) (
    input  logic          clock,
    input  logic          reset,
    exibe_frame_if.master bus
);

    // One spare bit so the bit counter can step past COLUNAS-1 without wrapping.
    localparam int              BW           = $clog2(COLUNAS + 1);
    localparam logic [BW-1:0]   BIT_ULTIMO   = BW'(COLUNAS - 1);
    localparam logic [3:0]      LINHA_ULTIMA = 4'(LINHAS - 1);

    estado_t       estado, proximo;
    logic [3:0]    linha;
    logic [BW-1:0] bit_cnt;
    logic          msb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ST_INICIAL;
        else        estado <= proximo;
    end

    // NOTE: proximo gets a default before the case so no path infers a latch.
    always_comb begin
        proximo = ST_INICIAL;
        case (estado)
            ST_INICIAL:       proximo = ST_ESPERA;
            ST_ESPERA:        proximo = bus.fim_gera_frame ? ST_LE_LINHA : ST_ESPERA;
            ST_LE_LINHA:      proximo = ST_CARREGA;
            ST_CARREGA:       proximo = ST_DESLOCA;
            ST_DESLOCA:       proximo = (bit_cnt == BIT_ULTIMO) ? ST_TRAVA : ST_DESLOCA;
            ST_TRAVA:         proximo = ST_PROXIMA_LINHA;
            ST_PROXIMA_LINHA: proximo = (linha == LINHA_ULTIMA) ? ST_SINALIZA : ST_LE_LINHA;
            ST_SINALIZA:      proximo = ST_ESPERA;
            default:          proximo = ST_INICIAL;
        endcase
    end

    // The row counter only advances when another row follows, so it never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            linha   <= '0;
            bit_cnt <= '0;
        end else begin
            if (estado == ST_ESPERA && bus.fim_gera_frame)
                linha <= '0;
            else if (estado == ST_PROXIMA_LINHA && linha != LINHA_ULTIMA)
                linha <= linha + 4'd1;

            if (estado == ST_CARREGA)
                bit_cnt <= '0;
            else if (estado == ST_DESLOCA)
                bit_cnt <= bit_cnt + BW'(1);
        end
    end

    registrador_deslocamento_linha #(.COLUNAS(COLUNAS)) u_registrador (
        .clock   (clock),
        .reset   (reset),
        .carrega (estado == ST_CARREGA),
        .desloca (estado == ST_DESLOCA),
        .dado    (bus.dado_frame),
        .msb     (msb)
    );

    assign bus.le_frame       = (estado == ST_LE_LINHA);
    assign bus.endereco_frame = linha;
    assign bus.linha_ativa    = linha;
    assign bus.strobe_serial  = (estado == ST_DESLOCA);
    assign bus.dado_serial    = (estado == ST_DESLOCA) && msb;
    assign bus.trava_linha    = (estado == ST_TRAVA);
    assign bus.fim_exibe      = (estado == ST_SINALIZA);
    assign bus.ocupado        = (estado >= ST_LE_LINHA) && (estado <= ST_SINALIZA);
    assign bus.db_estado      = estado;

endmodule

// File: tb/tb_exibe_frame.sv
// Scoreboard bench for exibe_frame: a frame model queues the expected serial
// bits, latch pulses and end-of-frame; a monitor compares what the DUT emits.
module tb_exibe_frame;
    import astrogenius_pkg::*;

    localparam int LIN = 16;
    localparam int COL = 16;
    localparam int CICLOS_LINHA = COL + 4;
    localparam int CICLOS_FRAME = LIN * CICLOS_LINHA;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    exibe_frame_if #(.COLUNAS(COL)) bus ();
    exibe_frame #(.LINHAS(LIN), .COLUNAS(COL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {EV_BIT = 0, EV_TRAVA = 1, EV_FIM = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    ev_t            fila[$];
    logic [COL-1:0] mem [LIN];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, t_start = 0, fim_count = 0, trava_count = 0, t_trava = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    // Reference: a frame is every row MSB-first, each followed by its latch, then one end pulse.
    task automatic expect_frame();
        ev_t e;
        for (int r = 0; r < LIN; r++) begin
            for (int c = COL - 1; c >= 0; c--) begin
                e.kind = EV_BIT;
                e.val  = int'(mem[r][c]);
                fila.push_back(e);
            end
            e.kind = EV_TRAVA;
            e.val  = r;
            fila.push_back(e);
        end
        e.kind = EV_FIM;
        e.val  = 0;
        fila.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t k, input logic [31:0] atual, input string nome);
        ev_t e;
        if (fila.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: unexpected output %0h with nothing expected (cycle %0d)", nome, atual, cyc);
            return;
        end
        e = fila.pop_front();
        check({nome, "_kind"}, int'(e.kind), int'(k));
        if (e.kind == k) check(nome, atual, e.val);
    endtask

    // Frame memory: data appears one cycle after the read strobe, garbage otherwise.
    logic       pend = 1'b0;
    logic [3:0] pend_addr = '0;
    always @(negedge clock) begin
        if (pend) bus.dado_frame = mem[pend_addr];
        else      bus.dado_frame = COL'($urandom);
        pend      = bus.le_frame;
        pend_addr = bus.endereco_frame;
    end

    always @(negedge clock) begin
        if (reset) begin
            cyc++;
            if (bus.le_frame && bus.endereco_frame == 4'd0) t_start = cyc;
            if (bus.strobe_serial) pop_check(EV_BIT, bus.dado_serial, "serial_bit");
            if (!bus.strobe_serial && bus.dado_serial !== 1'b0)
                check("dado_outside_shift", bus.dado_serial, 0);
            if (bus.trava_linha) begin
                trava_count++;
                pop_check(EV_TRAVA, bus.linha_ativa, "linha_ativa");
                check("ocupado_trava", bus.ocupado, 1);
                if (bus.linha_ativa != 4'd0) check("row_period", cyc - t_trava, CICLOS_LINHA);
                t_trava = cyc;
            end
            if (bus.fim_exibe) begin
                fim_count++;
                pop_check(EV_FIM, 0, "fim_exibe");
                check("frame_latency", cyc - t_start, CICLOS_FRAME);
                check("ocupado_fim", bus.ocupado, 1);
            end
        end
    end

    task automatic pulse_fim_gera();
        bus.fim_gera_frame = 1'b1;
        @(negedge clock);
        bus.fim_gera_frame = 1'b0;
    endtask

    task automatic wait_fim(input int budget);
        int alvo = fim_count + 1;
        for (int i = 0; i < budget && fim_count < alvo; i++) @(negedge clock);
        check("fim_timeout", fim_count >= alvo, 1);
    endtask

    task automatic random_frame();
        for (int r = 0; r < LIN; r++) mem[r] = COL'($urandom);
    endtask

    task automatic check_idle(input string nome);
        check({nome, "_estado"}, bus.db_estado, 1);
        check({nome, "_le"}, bus.le_frame, 0);
        check({nome, "_strobe"}, bus.strobe_serial, 0);
        check({nome, "_trava"}, bus.trava_linha, 0);
        check({nome, "_fim"}, bus.fim_exibe, 0);
        check({nome, "_ocupado"}, bus.ocupado, 0);
    endtask

    initial begin
        int fc, tc;
        bit achou;
        bus.fim_gera_frame = 1'b0;
        for (int r = 0; r < LIN; r++) mem[r] = '0;

        // Outputs while reset is held, then idle in espera
        repeat (3) @(negedge clock);
        check("rst_estado", bus.db_estado, 0);
        check("rst_le", bus.le_frame, 0);
        check("rst_serial", {bus.dado_serial, bus.strobe_serial}, 0);
        check("rst_trava", bus.trava_linha, 0);
        check("rst_linha", {bus.linha_ativa, bus.endereco_frame}, 0);
        check("rst_ocupado_fim", {bus.ocupado, bus.fim_exibe}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_idle("idle");

        // Row 0 = A5C3, remaining rows random
        random_frame();
        mem[0] = 16'hA5C3;
        expect_frame();
        pulse_fim_gera();
        wait_fim(CICLOS_FRAME + 20);
        repeat (3) @(negedge clock);
        check("queue_empty_a5c3", fila.size(), 0);

        // Walking one: row r = 1 << r
        for (int r = 0; r < LIN; r++) mem[r] = COL'(1) << r;
        tc = trava_count;
        expect_frame();
        pulse_fim_gera();
        wait_fim(CICLOS_FRAME + 20);
        repeat (3) @(negedge clock);
        check("trava_count_walk", trava_count - tc, LIN);
        check("queue_empty_walk", fila.size(), 0);

        // Second request at row 7 must be ignored
        random_frame();
        expect_frame();
        fc = fim_count;
        pulse_fim_gera();
        achou = 0;
        for (int i = 0; i < CICLOS_FRAME && !achou; i++) begin
            @(negedge clock);
            achou = (bus.linha_ativa == 4'd7);
        end
        check("reach_row7", achou, 1);
        pulse_fim_gera();
        repeat (CICLOS_FRAME + 40) @(negedge clock);
        check("single_fim", fim_count - fc, 1);
        check("queue_empty_row7", fila.size(), 0);
        check_idle("after_row7");

        // Reset during row 3 shifting aborts at once
        random_frame();
        expect_frame();
        pulse_fim_gera();
        achou = 0;
        for (int i = 0; i < CICLOS_FRAME && !achou; i++) begin
            @(negedge clock);
            achou = (bus.endereco_frame == 4'd3) && bus.strobe_serial;
        end
        check("reach_row3_shift", achou, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_serial", {bus.dado_serial, bus.strobe_serial}, 0);
        check("abort_trava_fim", {bus.trava_linha, bus.fim_exibe}, 0);
        check("abort_estado", bus.db_estado, 0);
        check("abort_linha", bus.linha_ativa, 0);
        fila.delete();
        fc = fim_count;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("espera_after_1cycle", bus.db_estado, 1);
        repeat (40) @(negedge clock);
        check("no_fim_after_abort", fim_count - fc, 0);
        check_idle("after_abort");

        // Request arriving in sinaliza is dropped; the next one starts at row 0
        random_frame();
        expect_frame();
        pulse_fim_gera();
        achou = 0;
        for (int i = 0; i < CICLOS_FRAME + 20 && !achou; i++) begin
            @(negedge clock);
            achou = (bus.db_estado == 4'd7);
        end
        check("reach_sinaliza", achou, 1);
        pulse_fim_gera();
        repeat (3) @(negedge clock);
        check_idle("sinaliza_pulse_ignored");
        check("queue_empty_sinaliza", fila.size(), 0);
        random_frame();
        expect_frame();
        pulse_fim_gera();
        wait_fim(CICLOS_FRAME + 20);
        repeat (3) @(negedge clock);
        check("queue_empty_last", fila.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
